// File: rtl/buffer_pkg.sv
// Shared definitions for the buffer fill controller: default word width,
// buffer geometry and the fill-state encoding.
package buffer_pkg;

    localparam int DEF_DATA_WIDTH = 40;
    localparam int DEPTH          = 4;
    localparam int PTR_W          = 2;
    localparam int LVL_W          = 3;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fill_state_t;

endpackage

// File: rtl/buffer_fill_ctrl_if.sv
// Bus between the upstream producer, the buffer controller and the
// downstream slot mux. The optional stall counter output appears only when
// BUFFER_FILL_STALL_CNT_EN is defined.
//
// Handshake: a word moves on a rising edge where valid and ready are both 1.
// in_ready and out_valid depend only on registered state, never on the
// partner's valid/ready, so there is no combinational loop through the bus.
// The producer holds in_valid and in_data stable until it sees in_ready.
interface buffer_fill_ctrl_if #(
    parameter int DATA_WIDTH = buffer_pkg::DEF_DATA_WIDTH
);
    import buffer_pkg::*;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] buf_data0;
    logic [DATA_WIDTH-1:0] buf_data1;
    logic [DATA_WIDTH-1:0] buf_data2;
    logic [DATA_WIDTH-1:0] buf_data3;
    logic [PTR_W-1:0]      sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [LVL_W-1:0]      level;
    fill_state_t           fsm_state;
`ifdef BUFFER_FILL_STALL_CNT_EN
    logic [7:0]            stall_cnt;
`endif

`ifdef BUFFER_FILL_STALL_CNT_EN
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, buf_data0, buf_data1, buf_data2, buf_data3,
               sel, out_valid, level, fsm_state, stall_cnt
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, buf_data0, buf_data1, buf_data2, buf_data3,
               sel, out_valid, level, fsm_state, stall_cnt
    );
`else
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, buf_data0, buf_data1, buf_data2, buf_data3,
               sel, out_valid, level, fsm_state
    );
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, buf_data0, buf_data1, buf_data2, buf_data3,
               sel, out_valid, level, fsm_state
    );
`endif

endinterface

// File: rtl/buffer_fill_ptr.sv
// 2-bit wrapping pointer with synchronous clear (clear wins over increment).
module buffer_fill_ptr
    import buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [PTR_W-1:0] ptr
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Next pointer: clear, step (natural wrap 3 -> 0) or hold.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/buffer_fill_ctrl.sv
// Four-slot circular buffer controller. Storage slots are exposed directly
// to an external mux whose selector is the read pointer.
// Optional feature: define BUFFER_FILL_STALL_CNT_EN to add a saturating
// count of cycles where the producer is held off by a full buffer.
module buffer_fill_ctrl
    import buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    buffer_fill_ctrl_if.slave    bus
);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [LVL_W-1:0]      level_q;
    logic [LVL_W-1:0]      level_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    fill_state_t           state_q;
    logic                  in_ready;
    logic                  out_valid;
    logic                  push;
    logic                  pop;

    // Flow control comes from the registered level only.
    assign in_ready  = (level_q < LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = bus.in_valid & in_ready;
    assign pop       = out_valid & bus.out_ready;

    buffer_fill_ptr u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (push),
        .clr   (flush),
        .ptr   (wr_ptr)
    );

    buffer_fill_ptr u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pop),
        .clr   (flush),
        .ptr   (rd_ptr)
    );

    // Occupancy: flush clears; a simultaneous push and pop cancel out.
    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // Slot write: flush suppresses the write so storage stays as it was.
    always_comb begin
        mem_d = mem_q;
        if (push && !flush) begin
            mem_d[wr_ptr] = bus.in_data;
        end
    end

    // Level and storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            level_q <= level_d;
            mem_q   <= mem_d;
        end
    end

    // Fill-state FSM, tracking the level transitions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) state_q <= PARTIAL;
                end
                PARTIAL: begin
                    if (level_d == LVL_W'(DEPTH)) begin
                        state_q <= FULL;
                    end else if (level_d == '0) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) state_q <= PARTIAL;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifdef BUFFER_FILL_STALL_CNT_EN
    logic [7:0] stall_cnt_q;
    logic [7:0] stall_cnt_d;

    // Count producer stalls, saturating at 255; flush clears.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (bus.in_valid && !in_ready && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.sel       = rd_ptr;
    assign bus.level     = level_q;
    assign bus.fsm_state = state_q;
    assign bus.buf_data0 = mem_q[0];
    assign bus.buf_data1 = mem_q[1];
    assign bus.buf_data2 = mem_q[2];
    assign bus.buf_data3 = mem_q[3];

endmodule

// File: tb/tb_buffer_fill_ctrl.sv
// Testbench for buffer_fill_ctrl: directed scenarios plus a randomized run
// against a queue-level reference model.
module tb_buffer_fill_ctrl;
    import buffer_pkg::*;

    localparam int DW = 40;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    buffer_fill_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    buffer_fill_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    logic [DW-1:0] obs_slot [4];
    logic [DW-1:0] mux_out;
    assign obs_slot[0] = bus.buf_data0;
    assign obs_slot[1] = bus.buf_data1;
    assign obs_slot[2] = bus.buf_data2;
    assign obs_slot[3] = bus.buf_data3;
    assign mux_out     = obs_slot[bus.sel];

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Buffer as a count of unread words plus running write/read positions
    // modulo the depth; slots hold whatever was last written there.
    int            m_cnt;
    int            m_wr;
    int            m_rd;
    int            m_stall;
    logic [DW-1:0] m_slot [4];

    function automatic fill_state_t m_state();
        if (m_cnt == 0) return EMPTY;
        if (m_cnt == 4) return FULL;
        return PARTIAL;
    endfunction

    function automatic logic [6:0] m_status();
        return {3'(m_cnt), 2'(m_rd), (m_cnt < 4), (m_cnt != 0)};
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_wr = 0; m_rd = 0; m_stall = 0;
        for (int i = 0; i < 4; i++) m_slot[i] = '0;
    endtask

    // ---------------- driver ----------------
    // Advance one clock, update the model with the inputs seen at that
    // edge, and return 1 time unit after the edge.
    task automatic cycle();
        logic          iv, ordy, fl;
        logic [DW-1:0] d;
        int            cnt0;
        iv = bus.in_valid; ordy = bus.out_ready; fl = flush; d = bus.in_data;
        cnt0 = m_cnt;
        @(posedge clk);
        if (fl) begin
            m_cnt = 0; m_wr = 0; m_rd = 0; m_stall = 0;
        end else begin
            if (iv && cnt0 < 4) begin
                m_slot[m_wr] = d; m_wr = (m_wr + 1) % 4; m_cnt++;
            end
            if (ordy && cnt0 > 0) begin
                m_rd = (m_rd + 1) % 4; m_cnt--;
            end
            if (iv && cnt0 == 4 && m_stall < 255) m_stall++;
        end
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_flush();
        idle_inputs(); flush = 1'b1; cycle(); flush = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.in_valid = 1'b1; bus.in_data = 40'h55; bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (bus.level !== 3'd0 || bus.sel !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got level=%0d sel=%0d in_ready=%b out_valid=%b want 0 0 1 0",
                     bus.level, bus.sel, bus.in_ready, bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_slot[i] !== '0) begin
                errors++;
                $display("FAIL reset_slot%0d got %h want 0", i, obs_slot[i]);
            end
        end
        checks++;
        if (bus.fsm_state !== EMPTY) begin
            errors++;
            $display("FAIL reset_state got %0d want EMPTY", bus.fsm_state);
        end
        idle_inputs();
    endtask

    task automatic test_first_push();
        rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 40'hABA;
        cycle();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.buf_data0 !== 40'hABA) begin
            errors++;
            $display("FAIL first_push_data got %h want aba", bus.buf_data0);
        end
        checks++;
        if (bus.level !== 3'd1 || bus.out_valid !== 1'b1 || bus.sel !== 2'd0) begin
            errors++;
            $display("FAIL first_push_flags got level=%0d out_valid=%b sel=%0d want 1 1 0",
                     bus.level, bus.out_valid, bus.sel);
        end
    endtask

    task automatic test_fill_full();
        do_flush();
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1; bus.in_data = DW'(i);
            cycle();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (bus.level !== 3'd4 || bus.in_ready !== 1'b0 || bus.fsm_state !== FULL) begin
            errors++;
            $display("FAIL full_flags got level=%0d in_ready=%b state=%0d want 4 0 FULL",
                     bus.level, bus.in_ready, bus.fsm_state);
        end
        bus.in_valid = 1'b1; bus.in_data = 40'h5;
        cycle();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.buf_data0 !== 40'h1 || bus.level !== 3'd4) begin
            errors++;
            $display("FAIL full_reject got slot0=%h level=%0d want 1 4", bus.buf_data0, bus.level);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.sel !== 2'(i) || mux_out !== DW'(i + 1)) begin
                errors++;
                $display("FAIL drain_%0d got sel=%0d mux=%h want %0d %h", i, bus.sel, mux_out, i, i + 1);
            end
            bus.out_ready = 1'b1;
            cycle();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (bus.sel !== 2'd0 || bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.fsm_state !== EMPTY) begin
            errors++;
            $display("FAIL drain_end got sel=%0d level=%0d out_valid=%b state=%0d want 0 0 0 EMPTY",
                     bus.sel, bus.level, bus.out_valid, bus.fsm_state);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] w [8];
        for (int i = 0; i < 8; i++) w[i] = 40'h100 + DW'(i);
        do_flush();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1; bus.in_data = w[i]; cycle();
        end
        for (int k = 0; k < 6; k++) begin
            bus.in_valid = 1'b1; bus.out_ready = 1'b1; bus.in_data = w[2 + k];
            cycle();
            checks++;
            if (bus.level !== 3'd2) begin
                errors++;
                $display("FAIL b2b_level_%0d got %0d want 2", k, bus.level);
            end
        end
        idle_inputs();
        checks++;
        if (bus.buf_data0 !== w[4] || bus.buf_data3 !== w[7]) begin
            errors++;
            $display("FAIL b2b_wrap got slot0=%h slot3=%h want %h %h", bus.buf_data0, bus.buf_data3, w[4], w[7]);
        end
        checks++;
        if (bus.sel !== 2'd2 || mux_out !== w[6]) begin
            errors++;
            $display("FAIL b2b_head got sel=%0d mux=%h want 2 %h", bus.sel, mux_out, w[6]);
        end
    endtask

    task automatic test_flush();
        logic [DW-1:0] slot3;
        do_flush();
        bus.in_valid = 1'b1;
        bus.in_data = 40'hA0; cycle();
        bus.in_data = 40'hB0; cycle();
        bus.in_data = 40'hC0; cycle();
        slot3 = m_slot[3];
        bus.in_data = 40'hD0; bus.out_ready = 1'b1; flush = 1'b1;
        cycle();
        idle_inputs();
        checks++;
        if (bus.level !== 3'd0 || bus.sel !== 2'd0 || bus.out_valid !== 1'b0 || bus.fsm_state !== EMPTY) begin
            errors++;
            $display("FAIL flush_flags got level=%0d sel=%0d out_valid=%b state=%0d want 0 0 0 EMPTY",
                     bus.level, bus.sel, bus.out_valid, bus.fsm_state);
        end
        checks++;
        if (bus.buf_data0 !== 40'hA0 || bus.buf_data1 !== 40'hB0 || bus.buf_data2 !== 40'hC0 || bus.buf_data3 !== slot3) begin
            errors++;
            $display("FAIL flush_storage got %h %h %h %h want a0 b0 c0 %h",
                     bus.buf_data0, bus.buf_data1, bus.buf_data2, bus.buf_data3, slot3);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.in_data   = DW'({$urandom(), $urandom()});
            flush         = ($urandom_range(0, 31) == 0);
            cycle();
            checks++;
            if ({bus.level, bus.sel, bus.in_ready, bus.out_valid} !== m_status()) begin
                errors++;
                $display("FAIL rand_status_%0d got %b want %b", n,
                         {bus.level, bus.sel, bus.in_ready, bus.out_valid}, m_status());
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (obs_slot[i] !== m_slot[i]) begin
                    errors++;
                    $display("FAIL rand_slot%0d_%0d got %h want %h", i, n, obs_slot[i], m_slot[i]);
                end
            end
            checks++;
            if (bus.fsm_state !== m_state()) begin
                errors++;
                $display("FAIL rand_state_%0d got %0d want %0d", n, bus.fsm_state, m_state());
            end
`ifdef BUFFER_FILL_STALL_CNT_EN
            checks++;
            if (bus.stall_cnt !== 8'(m_stall)) begin
                errors++;
                $display("FAIL rand_stall_%0d got %0d want %0d", n, bus.stall_cnt, m_stall);
            end
`endif
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_flush();
        bus.in_valid = 1'b1;
        bus.in_data = 40'h77; cycle();
        bus.in_data = 40'h88; cycle();
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (bus.level !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.buf_data0 !== '0) begin
            errors++;
            $display("FAIL async_reset got level=%0d out_valid=%b in_ready=%b slot0=%h want 0 0 1 0",
                     bus.level, bus.out_valid, bus.in_ready, bus.buf_data0);
        end
        #1 rst_n = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 40'h99;
        cycle();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.buf_data0 !== 40'h99 || bus.level !== 3'd1 || bus.buf_data1 !== '0) begin
            errors++;
            $display("FAIL post_reset_push got slot0=%h level=%0d slot1=%h want 99 1 0",
                     bus.buf_data0, bus.level, bus.buf_data1);
        end
    endtask

`ifdef BUFFER_FILL_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_flush();
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_data = DW'(i); cycle();
        end
        repeat (300) cycle();
        checks++;
        if (bus.stall_cnt !== 8'd255) begin
            errors++;
            $display("FAIL stall_sat got %0d want 255", bus.stall_cnt);
        end
        do_flush();
        checks++;
        if (bus.stall_cnt !== 8'd0) begin
            errors++;
            $display("FAIL stall_flush got %0d want 0", bus.stall_cnt);
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        idle_inputs();
        bus.in_data = '0;
        test_reset();
        test_first_push();
        test_fill_full();
        test_drain();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef BUFFER_FILL_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/buffer_fill_ctrl.md
BUFFER_FILL_CTRL -- requirements
Module: buffer_fill_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 40, giving the width of every data word.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port flush, input, 1 bit: synchronous clear of pointers and level.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-006 SHALL have port in_data, input, DATA_WIDTH bits: upstream word.
REQ-007 SHALL have port in_ready, output, 1 bit: a slot is free.
REQ-008 SHALL have ports buf_data0, buf_data1, buf_data2 and buf_data3, each output, DATA_WIDTH bits: storage slots 0-3, driving the mux data inputs.
REQ-009 SHALL have port sel, output, 2 bits: read pointer, driving the mux selector.
REQ-010 SHALL have port out_valid, output, 1 bit: the slot at sel holds an unread word.
REQ-011 SHALL have port out_ready, input, 1 bit: the downstream consumes the word at sel this cycle.
REQ-012 SHALL have port level, output, 3 bits: occupancy, 0 to 4.

Function
REQ-013 SHALL implement a 4-entry circular buffer with write pointer wr_ptr and read pointer rd_ptr, both 2 bits wide and wrapping from 3 to 0.
REQ-014 SHALL define push as in_valid AND in_ready; on push, in_data is written to slot wr_ptr and wr_ptr increments.
REQ-015 SHALL define pop as out_valid AND out_ready; on pop, rd_ptr increments; slot contents are not cleared.
REQ-016 SHALL drive in_ready = (level < 4) and out_valid = (level != 0), both decoded from registered state only; there is no full-to-empty pass-through.
REQ-017 SHALL make a pushed word visible on buf_dataN, with level and out_valid updated, in the cycle after the push edge (1-cycle latency).
REQ-018 SHALL update level as follows: push only, +1; pop only, -1; push and pop in the same cycle, unchanged.
REQ-019 SHALL run an FSM with states EMPTY, PARTIAL and FULL: EMPTY goes to PARTIAL on push; PARTIAL goes to FULL when level reaches 4 and to EMPTY when level reaches 0; FULL goes to PARTIAL on pop.
REQ-020 SHALL ignore in_valid while FULL (in_ready=0) and SHALL ignore out_ready while EMPTY (out_valid=0).
REQ-021 SHALL, on flush, zero wr_ptr, rd_ptr and level and enter EMPTY; storage is retained; flush overrides any push or pop in the same cycle.
REQ-022 SHALL leave in_data sampling independent of out_ready; held in_valid with unchanged in_data while stalled is the upstream's duty.

Reset
REQ-023 SHALL, while rst_n=0, force wr_ptr=0, sel=0, level=0, buf_data0-3 = 0, in_ready=1, out_valid=0 and state EMPTY, regardless of clk.
REQ-024 SHALL discard any in-flight words on reset assertion mid-operation and SHALL accept a push on the first rising edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with BUFFER_FILL_STALL_CNT_EN defined, add output stall_cnt, 8 bits: a saturating count (holds at 255) of cycles where in_valid=1 and in_ready=0, cleared by reset and by flush.
REQ-026 SHALL, without BUFFER_FILL_STALL_CNT_EN, omit the stall_cnt port and its logic entirely, with all other behaviour unchanged.

Structure
REQ-027 SHALL take DATA_WIDTH default, DEPTH=4, PTR_W=2 and the state enum (EMPTY, PARTIAL, FULL) from shared package buffer_pkg.
REQ-028 SHALL instantiate sub-module buffer_fill_ptr twice (a 2-bit wrapping counter with inc and clr) for wr_ptr and rd_ptr.

Verification
REQ-029 SHALL cover: hold rst_n=0 -> all outputs at reset values; release rst_n, push 40'hABA -> next cycle buf_data0=40'hABA, level=1, out_valid=1, sel=0.
REQ-030 SHALL cover: push 40'h1, 40'h2, 40'h3, 40'h4 with out_ready=0 -> level=4, in_ready=0; a fifth in_valid -> no write, buf_data0 stays 40'h1.
REQ-031 SHALL cover: from full, pop 4 times -> sel steps 0,1,2,3,0 and the mux outputs 40'h1, 40'h2, 40'h3, 40'h4; then level=0, out_valid=0.
REQ-032 SHALL cover: push 6 words with a concurrent pop each cycle from level=2 -> level holds at 2; wr_ptr wraps to slot 0 and overwrites it.
REQ-033 SHALL cover: flush asserted in the same cycle as push and pop at level=3 -> level=0 and sel=0 next cycle, storage unchanged.
REQ-034 SHALL cover, with BUFFER_FILL_STALL_CNT_EN defined: in_valid held for 300 cycles while full -> stall_cnt=255; flush -> stall_cnt=0.
